main_crc_switch: RTL and testbench

- 16-port, CRC-checked, single-transfer-per-cycle crossbar.
- Each cycle, one source port (senderAddress) offers a 64-bit word and its 4-bit CRC.
- If the CRC verifies, the word is registered onto the destination output (receiverAddress).
- All other outputs hold their last value. Sits between the 16 node data sources and their receive registers.

---
 rtl/main_crc_switch.sv | 158 +++++++++++++++
 tb/tb_main_crc_switch.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/main_crc_switch.sv
// 16-port CRC-checked crossbar: one source word per cycle is registered onto one destination output.
// Optional CRC_CHECK_EN builds the CRC-4 checker; without it every cycle forwards unconditionally.
module main_crc_switch #(
  parameter int                 DATA_W   = 64,
  parameter int                 CRC_W    = 4,
  parameter logic [CRC_W-1:0]   CRC_POLY = 4'h3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [CRC_W-1:0]  CRC1,
  input  logic [CRC_W-1:0]  CRC2,
  input  logic [CRC_W-1:0]  CRC3,
  input  logic [CRC_W-1:0]  CRC4,
  input  logic [CRC_W-1:0]  CRC5,
  input  logic [CRC_W-1:0]  CRC6,
  input  logic [CRC_W-1:0]  CRC7,
  input  logic [CRC_W-1:0]  CRC8,
  input  logic [CRC_W-1:0]  CRC9,
  input  logic [CRC_W-1:0]  CRC10,
  input  logic [CRC_W-1:0]  CRC11,
  input  logic [CRC_W-1:0]  CRC12,
  input  logic [CRC_W-1:0]  CRC13,
  input  logic [CRC_W-1:0]  CRC14,
  input  logic [CRC_W-1:0]  CRC15,
  input  logic [CRC_W-1:0]  CRC16,
  input  logic [DATA_W-1:0] Data1,
  input  logic [DATA_W-1:0] Data2,
  input  logic [DATA_W-1:0] Data3,
  input  logic [DATA_W-1:0] Data4,
  input  logic [DATA_W-1:0] Data5,
  input  logic [DATA_W-1:0] Data6,
  input  logic [DATA_W-1:0] Data7,
  input  logic [DATA_W-1:0] Data8,
  input  logic [DATA_W-1:0] Data9,
  input  logic [DATA_W-1:0] Data10,
  input  logic [DATA_W-1:0] Data11,
  input  logic [DATA_W-1:0] Data12,
  input  logic [DATA_W-1:0] Data13,
  input  logic [DATA_W-1:0] Data14,
  input  logic [DATA_W-1:0] Data15,
  input  logic [DATA_W-1:0] Data16,
  input  logic [3:0]        senderAddress,
  input  logic [3:0]        receiverAddress,
  output logic [DATA_W-1:0] DataOut1,
  output logic [DATA_W-1:0] DataOut2,
  output logic [DATA_W-1:0] DataOut3,
  output logic [DATA_W-1:0] DataOut4,
  output logic [DATA_W-1:0] DataOut5,
  output logic [DATA_W-1:0] DataOut6,
  output logic [DATA_W-1:0] DataOut7,
  output logic [DATA_W-1:0] DataOut8,
  output logic [DATA_W-1:0] DataOut9,
  output logic [DATA_W-1:0] DataOut10,
  output logic [DATA_W-1:0] DataOut11,
  output logic [DATA_W-1:0] DataOut12,
  output logic [DATA_W-1:0] DataOut13,
  output logic [DATA_W-1:0] DataOut14,
  output logic [DATA_W-1:0] DataOut15,
  output logic [DATA_W-1:0] DataOut16
);

  logic [DATA_W-1:0] w_data    [16];
  logic [DATA_W-1:0] r_dout_p1 [16];
  logic [DATA_W-1:0] w_sel_data_p0;
  logic              w_wr_en_p0;

  assign w_data[0]  = Data1;
  assign w_data[1]  = Data2;
  assign w_data[2]  = Data3;
  assign w_data[3]  = Data4;
  assign w_data[4]  = Data5;
  assign w_data[5]  = Data6;
  assign w_data[6]  = Data7;
  assign w_data[7]  = Data8;
  assign w_data[8]  = Data9;
  assign w_data[9]  = Data10;
  assign w_data[10] = Data11;
  assign w_data[11] = Data12;
  assign w_data[12] = Data13;
  assign w_data[13] = Data14;
  assign w_data[14] = Data15;
  assign w_data[15] = Data16;

  assign w_sel_data_p0 = w_data[senderAddress];

`ifdef CRC_CHECK_EN
  logic [CRC_W-1:0] w_crc    [16];
  logic [CRC_W-1:0] w_sel_crc_p0;
  logic [CRC_W-1:0] w_calc_crc_p0;

  // Serial MSB-first LFSR unrolled: yields d(x)*x^CRC_W mod generator.
  function automatic logic [CRC_W-1:0] crc_calc(input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ d[i];
      c  = {c[CRC_W-2:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

  assign w_crc[0]  = CRC1;
  assign w_crc[1]  = CRC2;
  assign w_crc[2]  = CRC3;
  assign w_crc[3]  = CRC4;
  assign w_crc[4]  = CRC5;
  assign w_crc[5]  = CRC6;
  assign w_crc[6]  = CRC7;
  assign w_crc[7]  = CRC8;
  assign w_crc[8]  = CRC9;
  assign w_crc[9]  = CRC10;
  assign w_crc[10] = CRC11;
  assign w_crc[11] = CRC12;
  assign w_crc[12] = CRC13;
  assign w_crc[13] = CRC14;
  assign w_crc[14] = CRC15;
  assign w_crc[15] = CRC16;

  assign w_sel_crc_p0  = w_crc[senderAddress];
  assign w_calc_crc_p0 = crc_calc(w_sel_data_p0);
  assign w_wr_en_p0    = (w_calc_crc_p0 == w_sel_crc_p0);
`else
  // CRC ports exist for interface compatibility only; fold them into one ignored net.
  logic w_unused_crc;
  assign w_unused_crc = ^{CRC_POLY, CRC1, CRC2, CRC3, CRC4, CRC5, CRC6, CRC7, CRC8,
                          CRC9, CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16};
  assign w_wr_en_p0   = 1'b1;
`endif

  // Stage p0 -> p1: registered delivery to the addressed output only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) r_dout_p1[i] <= '0;
    end else if (w_wr_en_p0) begin
      r_dout_p1[receiverAddress] <= w_sel_data_p0;
    end
  end

  assign DataOut1  = r_dout_p1[0];
  assign DataOut2  = r_dout_p1[1];
  assign DataOut3  = r_dout_p1[2];
  assign DataOut4  = r_dout_p1[3];
  assign DataOut5  = r_dout_p1[4];
  assign DataOut6  = r_dout_p1[5];
  assign DataOut7  = r_dout_p1[6];
  assign DataOut8  = r_dout_p1[7];
  assign DataOut9  = r_dout_p1[8];
  assign DataOut10 = r_dout_p1[9];
  assign DataOut11 = r_dout_p1[10];
  assign DataOut12 = r_dout_p1[11];
  assign DataOut13 = r_dout_p1[12];
  assign DataOut14 = r_dout_p1[13];
  assign DataOut15 = r_dout_p1[14];
  assign DataOut16 = r_dout_p1[15];

endmodule

// File: tb/tb_main_crc_switch.sv
// Directed bench for main_crc_switch with hand-computed CRC-4 vectors; tracks all 16 outputs.
module tb_main_crc_switch;
  logic        clock;
  logic        reset_n;
  logic [63:0] data [16];
  logic [3:0]  crc  [16];
  logic [3:0]  sender;
  logic [3:0]  receiver;
  logic [63:0] dout [16];
  logic [63:0] exp_out [16];
  int          n_checks;
  int          n_fail;

  main_crc_switch dut (
    .clock(clock), .reset_n(reset_n),
    .CRC1(crc[0]),   .CRC2(crc[1]),   .CRC3(crc[2]),   .CRC4(crc[3]),
    .CRC5(crc[4]),   .CRC6(crc[5]),   .CRC7(crc[6]),   .CRC8(crc[7]),
    .CRC9(crc[8]),   .CRC10(crc[9]),  .CRC11(crc[10]), .CRC12(crc[11]),
    .CRC13(crc[12]), .CRC14(crc[13]), .CRC15(crc[14]), .CRC16(crc[15]),
    .Data1(data[0]),   .Data2(data[1]),   .Data3(data[2]),   .Data4(data[3]),
    .Data5(data[4]),   .Data6(data[5]),   .Data7(data[6]),   .Data8(data[7]),
    .Data9(data[8]),   .Data10(data[9]),  .Data11(data[10]), .Data12(data[11]),
    .Data13(data[12]), .Data14(data[13]), .Data15(data[14]), .Data16(data[15]),
    .senderAddress(sender), .receiverAddress(receiver),
    .DataOut1(dout[0]),   .DataOut2(dout[1]),   .DataOut3(dout[2]),   .DataOut4(dout[3]),
    .DataOut5(dout[4]),   .DataOut6(dout[5]),   .DataOut7(dout[6]),   .DataOut8(dout[7]),
    .DataOut9(dout[8]),   .DataOut10(dout[9]),  .DataOut11(dout[10]), .DataOut12(dout[11]),
    .DataOut13(dout[12]), .DataOut14(dout[13]), .DataOut15(dout[14]), .DataOut16(dout[15])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      assert (dout[i] === exp_out[i])
        else begin
          n_fail++;
          $error("FAIL %s DataOut%0d observed=%h expected=%h", tag, i + 1, dout[i], exp_out[i]);
        end
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 16; i++) begin
      data[i] = 64'h0;
      crc[i]  = 4'h0;
    end
    sender   = 4'd0;
    receiver = 4'd0;
  endtask

  // Drive one transfer, take exactly one rising edge, then sample 1 time unit later.
  task automatic xfer(input logic [3:0] s, input logic [3:0] r,
                      input logic [63:0] d, input logic [3:0] c);
    data[s]  = d;
    crc[s]   = c;
    sender   = s;
    receiver = r;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 16; i++) begin
      data[i]    = 64'hA5A5_0000_0000_0000 | 64'(i + 1);
      crc[i]     = 4'(i);
      exp_out[i] = 64'h0;
    end
    sender   = 4'd3;
    receiver = 4'd7;
    reset_n  = 1'b1;

    // Asynchronous reset: outputs clear before any clock edge.
    #1 reset_n = 1'b0;
    #1 check_all("reset_async");
    repeat (3) @(posedge clock);
    #1 check_all("reset_held");

    @(negedge clock);
    clear_inputs();
    reset_n = 1'b1;

    xfer(4'd0, 4'd0, 64'h0, 4'h0);
    check_all("zero_word");

    xfer(4'd2, 4'd9, 64'h1, 4'h3);
    exp_out[9] = 64'h1;
    check_all("good_crc_1");

    xfer(4'd4, 4'd9, 64'h2, 4'h6);
    exp_out[9] = 64'h2;
    check_all("good_crc_2");

    // Preload DataOut1 so a dropped word is distinguishable from zero.
    xfer(4'd4, 4'd0, 64'h2, 4'h6);
    exp_out[0] = 64'h2;
    check_all("preload_out1");

    xfer(4'd6, 4'd0, 64'h1, 4'h0);
`ifdef CRC_CHECK_EN
    exp_out[0] = 64'h2;
`else
    exp_out[0] = 64'h1;
`endif
    check_all("bad_crc");

    // MSB-only word: x^67 mod (x^4+x+1) = x^7 = x^3+x+1.
    xfer(4'd8, 4'd12, 64'h8000_0000_0000_0000, 4'hB);
    exp_out[12] = 64'h8000_0000_0000_0000;
    check_all("msb_word");

    // 0xF * x^4 reduces to x.
    xfer(4'd10, 4'd3, 64'hF, 4'h2);
    exp_out[3] = 64'hF;
    check_all("nibble_word");

    xfer(4'd10, 4'd3, 64'hE, 4'h2);
`ifndef CRC_CHECK_EN
    exp_out[3] = 64'hE;
`endif
    check_all("bad_crc_2");

    xfer(4'd15, 4'd15, 64'h2, 4'h6);
    exp_out[15] = 64'h2;
    check_all("loopback");

    xfer(4'd15, 4'd15, 64'h2, 4'h6);
    check_all("repeat_hold");

    // Mid-stream reset pulse between edges.
    #1 reset_n = 1'b0;
    for (int i = 0; i < 16; i++) exp_out[i] = 64'h0;
    #1 check_all("reset_mid");
    reset_n = 1'b1;

    xfer(4'd2, 4'd5, 64'h1, 4'h3);
    exp_out[5] = 64'h1;
    check_all("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
